prog_launcher: RTL

Host-side sequencer that drives the CPU core's run handshake (core reset, req pulse, done sense) and sits in the test harness, outside the core. On one host start it runs NPROG programs back to back. For each program it:
- selects the program index,
- resets the core and pulses req,
- counts cycles until done,
- reports the count.
A watchdog aborts a program that never halts.

---
 rtl/prog_launcher_if.sv | 12 +
 rtl/prog_launcher.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/prog_launcher_if.sv
// Core run handshake between the launcher (master) and the CPU core under test (slave).
interface prog_launcher_if #(
    parameter int PW = 2
);
    logic          core_reset;
    logic          core_req;
    logic          core_done;
    logic [PW-1:0] prog_sel;

    modport master (output core_reset, output core_req, output prog_sel, input core_done);
    modport slave  (input core_reset, input core_req, input prog_sel, output core_done);
endinterface

// File: rtl/prog_launcher.sv
// Host-side sequencer: launches NPROG programs on the core, times each run, and aborts hung runs.
// Optional build macro PROG_LAUNCHER_DONE_SYNC_EN adds a 2-flop synchronizer on core_done.
module prog_launcher #(
    parameter int NPROG   = 3,
    parameter int CW      = 16,
    parameter int TIMEOUT = 4096,
    parameter int RST_CYC = 2,
    localparam int PW     = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic           clk,
    input  logic           reset,
    prog_launcher_if.master core,
    input  logic           start,
    output logic           busy,
    output logic           cyc_valid,
    output logic [CW-1:0]  cyc_cnt,
    output logic [PW-1:0]  cyc_prog,
    output logic           all_done,
    output logic           timeout_err
);

`ifdef PROG_LAUNCHER_DONE_SYNC_EN
    localparam int SKEW = 2;
`else
    localparam int SKEW = 0;
`endif
    // The synchronized build counts SKEW extra cycles, so it needs one spare counter bit.
    localparam int CNT_W = (SKEW > 0) ? CW + 1 : CW;
    localparam int RW    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT + SKEW);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_REQ, S_RUN, S_REPORT, S_FINISH
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [RW-1:0]    rst_cnt_reg;
    logic [PW-1:0]    prog_sel_reg;
    logic [CW-1:0]    cyc_cnt_reg;
    logic [PW-1:0]    cyc_prog_reg;
    logic             timeout_reg;
    logic             done_s;
    logic             last_prog;
    logic             core_reset_c, core_req_c, busy_c, cyc_valid_c, all_done_c;

`ifdef PROG_LAUNCHER_DONE_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_reg <= 2'b00;
        else        sync_reg <= {sync_reg[0], core.core_done};
    end
    assign done_s = sync_reg[1];
`else
    assign done_s = core.core_done;
`endif

    assign last_prog = (prog_sel_reg == PW'(NPROG - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        core_reset_c = 1'b1;
        core_req_c   = 1'b0;
        busy_c       = 1'b1;
        cyc_valid_c  = 1'b0;
        all_done_c   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                busy_c = 1'b0;
                if (start) state_next = S_RST;
            end
            S_RST: begin
                if (rst_cnt_reg == '0) state_next = S_REQ;
            end
            S_REQ: begin
                core_reset_c = 1'b0;
                core_req_c   = 1'b1;
                state_next   = S_RUN;
            end
            S_RUN: begin
                core_reset_c = 1'b0;
                if (done_s || cnt_reg == LIMIT) state_next = S_REPORT;
            end
            S_REPORT: begin
                core_reset_c = 1'b0;
                cyc_valid_c  = 1'b1;
                state_next   = (timeout_reg || last_prog) ? S_FINISH : S_RST;
            end
            S_FINISH: begin
                busy_c       = 1'b0;
                all_done_c   = 1'b1;
                // A hung core stays in reset; a cleanly halted one is left alone for inspection.
                core_reset_c = timeout_reg;
                if (start) state_next = S_RST;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg      <= '0;
            rst_cnt_reg  <= '0;
            prog_sel_reg <= '0;
            cyc_cnt_reg  <= '0;
            cyc_prog_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        prog_sel_reg <= '0;
                        timeout_reg  <= 1'b0;
                        rst_cnt_reg  <= RW'(RST_CYC - 1);
                    end
                end
                S_RST: begin
                    if (rst_cnt_reg != '0) rst_cnt_reg <= rst_cnt_reg - 1'b1;
                end
                S_REQ: begin
                    cnt_reg <= CNT_W'(1);
                end
                S_RUN: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (done_s) begin
                        cyc_cnt_reg  <= cnt_reg[CW-1:0] - CW'(SKEW);
                        cyc_prog_reg <= prog_sel_reg;
                    end else if (cnt_reg == LIMIT) begin
                        timeout_reg  <= 1'b1;
                        cyc_cnt_reg  <= CW'(TIMEOUT);
                        cyc_prog_reg <= prog_sel_reg;
                    end
                end
                S_REPORT: begin
                    if (!(timeout_reg || last_prog)) begin
                        prog_sel_reg <= prog_sel_reg + 1'b1;
                        rst_cnt_reg  <= RW'(RST_CYC - 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign core.core_reset = core_reset_c;
    assign core.core_req   = core_req_c;
    assign core.prog_sel   = prog_sel_reg;
    assign busy            = busy_c;
    assign cyc_valid       = cyc_valid_c;
    assign cyc_cnt         = cyc_cnt_reg;
    assign cyc_prog        = cyc_prog_reg;
    assign all_done        = all_done_c;
    assign timeout_err     = timeout_reg;

endmodule
